mode_indicator: RTL and testbench

- Drives a status LED that reports the active display mode to the user as a blink code.
- Blink count per burst = current_mode + 1; bursts are separated by a long pause and repeat indefinitely.
- Sits beside the button-driven mode selection logic: it consumes current_mode and the mode_changed pulse and gives the user feedback on the LED.
- Runs on the pixel clock domain; all timing is derived from CLK_FREQ.

---
 rtl/mode_indicator.sv | 127 ++++++++++++
 tb/tb_mode_indicator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mode_indicator.sv
// Status LED blink-code generator: each burst blinks (current_mode + 1) times,
// then holds off for a long pause. All timing derives from CLK_FREQ.
module mode_indicator #(
    parameter int unsigned NUM_MODES    = 6,
    parameter int unsigned CLK_FREQ     = 74_250_000,
    parameter int unsigned BLINK_ON_MS  = 150,
    parameter int unsigned BLINK_OFF_MS = 150,
    parameter int unsigned PAUSE_MS     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] current_mode,
    input  logic       mode_changed,
    input  logic       enable,
    output logic       led_n,
    output logic       burst_done
);

    localparam int unsigned ON_CYC    = (CLK_FREQ / 1000) * BLINK_ON_MS;
    localparam int unsigned OFF_CYC   = (CLK_FREQ / 1000) * BLINK_OFF_MS;
    localparam int unsigned PAUSE_CYC = (CLK_FREQ / 1000) * PAUSE_MS;
    localparam int unsigned MAX_A     = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int unsigned MAX_CYC   = (MAX_A > PAUSE_CYC) ? MAX_A : PAUSE_CYC;
    localparam int unsigned TW        = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_CYC - 1);
    localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_CYC - 1);
    localparam logic [2:0]    MODE_MAX   = 3'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        ON,
        OFF,
        PAUSE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;
    logic          done_d;
    logic [2:0]    mode_clamped;

    assign mode_clamped = (current_mode > MODE_MAX) ? MODE_MAX : current_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PAUSE;
            timer_q    <= '0;
            cnt_q      <= '0;
            mode_q     <= '0;
            led_n      <= 1'b1;
            burst_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            led_n      <= (state_d != ON);
            burst_done <= done_d;
        end
    end

    // cnt_q counts completed blinks; the burst ends when the blink now
    // finishing brings the total to mode_q + 1.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            timer_d = '0;
            cnt_d   = '0;
        end else if (mode_changed && state_q != IDLE) begin
            state_d = GAP;
            timer_d = '0;
            cnt_d   = '0;
            mode_d  = mode_clamped;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GAP;
                    timer_d = '0;
                    cnt_d   = '0;
                    mode_d  = mode_clamped;
                end
                GAP, OFF: begin
                    if (timer_q == OFF_LAST) begin
                        state_d = ON;
                        timer_d = '0;
                    end
                end
                ON: begin
                    if (timer_q == ON_LAST) begin
                        timer_d = '0;
                        if (cnt_q == mode_q) begin
                            state_d = PAUSE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = OFF;
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (timer_q == PAUSE_LAST) begin
                        state_d = ON;
                        timer_d = '0;
                        cnt_d   = '0;
                        mode_d  = mode_clamped;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_indicator.sv
// Directed bench for mode_indicator with ON_CYC=4, OFF_CYC=4, PAUSE_CYC=8.
module tb_mode_indicator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] current_mode = 3'd1;
    logic       mode_changed = 1'b0;
    logic       enable = 1'b1;
    logic       led_n;
    logic       burst_done;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic       en;
        logic       mc;
        logic [2:0] mode;
        int         len;
        logic       led;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    mode_indicator #(
        .NUM_MODES   (6),
        .CLK_FREQ    (4000),
        .BLINK_ON_MS (1),
        .BLINK_OFF_MS(1),
        .PAUSE_MS    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .current_mode(current_mode),
        .mode_changed(mode_changed),
        .enable      (enable),
        .led_n       (led_n),
        .burst_done  (burst_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Holds inputs for len cycles, checking outputs each cycle (sampled 1 unit after posedge).
    task automatic seg(input string name, input logic en, input logic mc,
                       input logic [2:0] mode, input int len,
                       input logic exp_led, input logic exp_done);
        for (int i = 0; i < len; i++) begin
            enable       = en;
            mode_changed = mc;
            current_mode = mode;
            check({name, " led_n"}, led_n, exp_led);
            check({name, " burst_done"}, burst_done, exp_done);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [2:0] mode);
        rst_n        = 1'b0;
        enable       = 1'b1;
        mode_changed = 1'b0;
        current_mode = mode;
        @(posedge clk);
        #1;
        check("reset led_n", led_n, 1'b1);
        check("reset burst_done", burst_done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic en, input logic mc, input logic [2:0] mode,
                                input int len, input logic led, input logic done);
        tbl.push_back(vec_t'{en, mc, mode, len, led, done});
    endfunction

    initial begin
        // Mode 1 from reset: pause 0-7, blinks 8-11 and 16-19, done at 20, next burst at 28
        add(1, 0, 1, 8, 1, 0);
        add(1, 0, 1, 4, 0, 0);
        add(1, 0, 1, 4, 1, 0);
        add(1, 0, 1, 4, 0, 0);
        add(1, 0, 1, 1, 1, 1);
        add(1, 0, 1, 7, 1, 0);
        add(1, 0, 1, 4, 0, 0);
        // Mode switched to 0 mid-burst without mode_changed: current burst still has 2 blinks
        add(1, 0, 0, 4, 1, 0);
        add(1, 0, 0, 4, 0, 0);
        add(1, 0, 0, 1, 1, 1);
        add(1, 0, 0, 7, 1, 0);
        add(1, 0, 0, 4, 0, 0);
        add(1, 0, 0, 1, 1, 1);
        add(1, 0, 0, 7, 1, 0);
        add(1, 0, 0, 4, 0, 0);
        add(1, 0, 0, 1, 1, 1);
        // Mode 7 clamps to 5: six blinks per burst
        add(1, 0, 7, 7, 1, 0);
        for (int k = 0; k < 5; k++) begin
            add(1, 0, 7, 4, 0, 0);
            add(1, 0, 7, 4, 1, 0);
        end
        add(1, 0, 7, 4, 0, 0);
        add(1, 0, 7, 1, 1, 1);
        add(1, 0, 7, 7, 1, 0);
        add(1, 0, 7, 4, 0, 0);

        do_reset(3'd1);
        foreach (tbl[i])
            seg($sformatf("tbl[%0d]", i), tbl[i].en, tbl[i].mc, tbl[i].mode,
                tbl[i].len, tbl[i].led, tbl[i].done);

        // mode_changed on 2nd ON cycle of blink 1, mode 1->3
        do_reset(3'd1);
        seg("mc pause",   1, 0, 1, 8, 1, 0);
        seg("mc on1",     1, 0, 1, 1, 0, 0);
        seg("mc pulse",   1, 1, 3, 1, 0, 0);
        seg("mc gap",     1, 0, 3, 4, 1, 0);
        for (int k = 0; k < 3; k++) begin
            seg("mc blink", 1, 0, 3, 4, 0, 0);
            seg("mc off",   1, 0, 3, 4, 1, 0);
        end
        seg("mc blink4",  1, 0, 3, 4, 0, 0);
        seg("mc done",    1, 0, 3, 1, 1, 1);
        // Back-to-back pulses: GAP restarts, first blink waits 4 quiet cycles
        seg("b2b pulses", 1, 1, 3, 2, 1, 0);
        seg("b2b gap",    1, 0, 3, 4, 1, 0);
        seg("b2b blink",  1, 0, 3, 4, 0, 0);
        seg("b2b off",    1, 0, 3, 1, 1, 0);

        // enable dropped mid-OFF, then re-enabled with mode 2
        seg("en low",     0, 0, 2, 10, 1, 0);
        seg("reen gap",   1, 0, 2, 5, 1, 0);
        for (int k = 0; k < 2; k++) begin
            seg("reen blink", 1, 0, 2, 4, 0, 0);
            seg("reen off",   1, 0, 2, 4, 1, 0);
        end
        seg("reen blink3", 1, 0, 2, 4, 0, 0);
        seg("reen done",   1, 0, 2, 1, 1, 1);

        // enable dropped on the last ON cycle: burst_done suppressed
        seg("sup pause",  1, 0, 2, 7, 1, 0);
        for (int k = 0; k < 2; k++) begin
            seg("sup blink", 1, 0, 2, 4, 0, 0);
            seg("sup off",   1, 0, 2, 4, 1, 0);
        end
        seg("sup last",   1, 0, 2, 3, 0, 0);
        seg("sup drop",   0, 0, 2, 1, 0, 0);
        seg("sup idle",   0, 0, 2, 4, 1, 0);

        // Asynchronous reset during ON
        seg("ar gap",     1, 0, 2, 5, 1, 0);
        seg("ar on",      1, 0, 2, 2, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset led_n", led_n, 1'b1);
        check("async reset burst_done", burst_done, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seg("ar pause",   1, 0, 2, 8, 1, 0);
        seg("ar blink",   1, 0, 2, 4, 0, 0);
        seg("ar off",     1, 0, 2, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
